rx_stream_packetizer: RTL and testbench
=======================================

# rx_stream_packetizer

Downstream stage of the RX controlled buffer. Consumes the buffer's AXI4-Stream sample output and cuts it into fixed-length packets with TLAST for the AXI DMA S2MM channel. Packet length and enable come from the buffer's AXI4-Lite register file. Output is registered through a skid slice, so throughput is one beat per cycle under arbitrary backpressure.

## Interface
- DATA_WIDTH, 64, stream data width in bits; must be ≥64 when the header is compiled in.
- LEN_WIDTH, 16, width of the packet-length field in beats.
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- s_axis_tdata  in  DATA_WIDTH  samples from the controlled buffer.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tlast  in  1  upstream end-of-capture; forces an early packet end.
- cfg_enable  in  1  packetizer enable (register-file bit).
- cfg_pkt_len  in  LEN_WIDTH  payload beats per packet; 0 means no packet starts.
- m_axis_tdata  out  DATA_WIDTH  data to DMA.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high while a packet is in progress (state ≠ IDLE).
- pkt_count  out  32  count of completed packets; wraps modulo 2^32.

## Operation
- States: IDLE, HDR (header builds only), DATA.
- IDLE: s_axis_tready=0. When cfg_enable=1 and cfg_pkt_len≠0:
  - latch cfg_pkt_len into len_q and clear beat_cnt;
  - go to HDR if the header is compiled in, otherwise to DATA.
- HDR: push one header beat into the skid slice, then go to DATA. No upstream beat is accepted in this state.
- DATA: s_axis_tready equals skid-slice ready. On each accepted beat, beat_cnt increments. tlast is set when beat_cnt==len_q−1 or s_axis_tlast=1, whichever comes first. After the tlast beat is accepted, return to IDLE.
- cfg_pkt_len changes mid-packet have no effect until the next packet.
- cfg_enable dropping mid-packet does not truncate: the current packet completes at len_q, then the block stays in IDLE.
- pkt_count increments when m_axis_tvalid & m_axis_tready & m_axis_tlast.
- Data order is preserved. No beat is dropped or duplicated.

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, pkt_count=0. State=IDLE and the skid slice is emptied.
- Latency: one cycle from an accepted upstream beat to m_axis_tvalid, when the slice is empty.
- IDLE→DATA takes one cycle. Each packet therefore costs one idle cycle, or two with the header.
- Standard AXI-Stream rules:
  - m_axis_tvalid is never withdrawn before m_axis_tready;
  - m_axis_tdata and m_axis_tlast are stable while stalled.
- s_axis_tready is a registered output, driven from skid-slice occupancy. It is never combinationally dependent on m_axis_tready.
- Simultaneous s_axis_tlast and beat_cnt==len_q−1 produce a single tlast and a single packet end.
- A reset mid-packet discards everything in flight at once. Downstream sees tvalid fall asynchronously.

## Configuration
- RX_PKT_HEADER_EN defined:
  - every packet begins with one header beat: [63:48]=16'hA55A, [47:32]=len_q, [31:0]=sequence number, bits above 63 zero;
  - the sequence number starts at 0 after reset and increments per packet;
  - tlast still falls on the last payload beat.
- RX_PKT_HEADER_EN undefined: HDR state and sequence counter are absent, and packets contain payload only.

## Structure
- Package rx_pkt_pkg holds:
  - the state enum;
  - header constants HDR_MAGIC=16'hA55A and the field bit positions;
  - the elaboration check DATA_WIDTH≥64 when the header is enabled.
- Sub-module rx_axis_skid is a two-entry register slice (DATA_WIDTH+1 bits: data plus last). It provides registered ready and valid.

## Test plan
- cfg_pkt_len=4, 12 continuous beats 0..11, m_axis_tready=1 → 3 packets with tlast on data 3, 7 and 11; pkt_count=3; busy low at the end.
- cfg_pkt_len=4, s_axis_tlast on the 2nd beat → 2-beat packet with tlast on beat 2; the next packet is a full 4 beats.
- cfg_pkt_len=8, 64 beats, m_axis_tready pseudo-random at 50% → output sequence identical to input, tlast every 8th beat, no stable-data violations.
- cfg_pkt_len changed 4→8 during beat 2, and cfg_enable dropped at beat 3 of the following packet → first packet 4 beats, second packet 8 beats, then s_axis_tready stays 0.
- RX_PKT_HEADER_EN, cfg_pkt_len=3, two packets → first beats 0xA55A000300000000 and 0xA55A000300000001, each followed by 3 payload beats.
- ARESETN asserted mid-packet, then released, with cfg_pkt_len=2 → outputs reset the same cycle, and the next packet is a clean 2 beats with pkt_count=1.

Source files
------------

// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the RX stream packetizer.
//
// Contents:
//   pkt_state_e    - packetizer FSM states (StHdr exists only with the header build)
//   HDR_*          - header beat layout: magic, length and sequence fields
//   hdr_width_ok   - elaboration check that the data path can carry a header beat
//   build_header   - assembles the 64-bit header word
//
// Build option: define RX_PKT_HEADER_EN to prefix every packet with a header beat.
package rx_pkt_pkg;

`ifdef RX_PKT_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle = 2'd0,
`ifdef RX_PKT_HEADER_EN
    StHdr  = 2'd1,
`endif
    StData = 2'd2
  } pkt_state_e;

  localparam logic [15:0] HDR_MAGIC     = 16'hA55A;
  localparam int unsigned HDR_WIDTH     = 64;
  localparam int unsigned HDR_MAGIC_MSB = 63;
  localparam int unsigned HDR_MAGIC_LSB = 48;
  localparam int unsigned HDR_LEN_MSB   = 47;
  localparam int unsigned HDR_LEN_LSB   = 32;
  localparam int unsigned HDR_SEQ_MSB   = 31;
  localparam int unsigned HDR_SEQ_LSB   = 0;

  // A header build needs at least 64 data bits; payload-only builds take any width.
  function automatic bit hdr_width_ok(input int unsigned data_width);
    return !HDR_EN || (data_width >= HDR_WIDTH);
  endfunction

  function automatic logic [63:0] build_header(input logic [15:0] len,
                                               input logic [31:0] seq);
    logic [63:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = HDR_MAGIC;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]     = len;
    hdr[HDR_SEQ_MSB:HDR_SEQ_LSB]     = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/rx_axis_skid.sv
// Two-entry AXI-Stream register slice with registered ready and valid.
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   in_valid_i     - upstream valid
//   in_ready_o     - upstream ready (registered: high while the skid entry is free)
//   in_data_i      - upstream payload
//   out_valid_o    - downstream valid (registered)
//   out_ready_i    - downstream ready
//   out_data_o     - downstream payload (registered, stable while stalled)
//
// The output register is the primary entry; the skid entry catches the one beat
// that can arrive in the cycle after downstream stalls, so in_ready_o never has
// a combinational path from out_ready_i.
module rx_axis_skid #(
  parameter int unsigned Width = 65
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             push, pop;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  assign push = in_valid_i & ~skid_valid_q;
  assign pop  = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || pop) begin
      // Output register frees up: refill from the skid entry first to keep order.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/rx_stream_packetizer.sv
// Cuts the RX buffer's sample stream into fixed-length packets with TLAST for
// the DMA S2MM channel. Output passes through a two-entry skid slice.
//
// Ports:
//   ACLK, ARESETN           - clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/
//     tready/tlast          - upstream samples; tlast forces an early packet end
//   cfg_enable, cfg_pkt_len - packetizer enable and payload beats per packet
//                             (length 0 keeps the block idle)
//   m_axis_tdata/tvalid/
//     tready/tlast          - packet stream to the DMA
//   busy                    - a packet is in progress
//   pkt_count               - completed packets, wraps modulo 2^32
//
// Build option: RX_PKT_HEADER_EN prefixes each packet with one header beat
// {16'hA55A, len[15:0], seq[31:0]}; DATA_WIDTH must then be at least 64.
module rx_stream_packetizer
  import rx_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  cfg_enable,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [31:0]           pkt_count
);

  if (!hdr_width_ok(DATA_WIDTH)) begin : g_width_check
    $error("DATA_WIDTH must be at least 64 when the packet header is enabled");
  end

  pkt_state_e state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]          pkt_count_q;
`ifdef RX_PKT_HEADER_EN
  logic [31:0]          seq_q, seq_d;
`endif

  logic                  skid_in_valid;
  logic                  skid_in_ready;
  logic [DATA_WIDTH-1:0] skid_in_data;
  logic                  skid_in_last;
  logic [DATA_WIDTH:0]   skid_out;
  logic                  pkt_end;

  // Length limit and upstream tlast coinciding still yield one packet end.
  assign pkt_end = (beat_cnt_q == (len_q - LEN_WIDTH'(1))) | s_axis_tlast;

  // Both terms are flops, so ready never depends on m_axis_tready in the same cycle.
  assign s_axis_tready = (state_q == StData) & skid_in_ready;
  assign busy          = (state_q != StIdle);
  assign pkt_count     = pkt_count_q;
  assign m_axis_tlast  = skid_out[DATA_WIDTH];
  assign m_axis_tdata  = skid_out[DATA_WIDTH-1:0];

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
`ifdef RX_PKT_HEADER_EN
    seq_d         = seq_q;
`endif
    skid_in_valid = 1'b0;
    skid_in_data  = '0;
    skid_in_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Length is sampled only here; mid-packet cfg changes wait for the next packet.
        if (cfg_enable && (cfg_pkt_len != '0)) begin
          len_d      = cfg_pkt_len;
          beat_cnt_d = '0;
`ifdef RX_PKT_HEADER_EN
          state_d    = StHdr;
`else
          state_d    = StData;
`endif
        end
      end
`ifdef RX_PKT_HEADER_EN
      StHdr: begin
        skid_in_valid = 1'b1;
        skid_in_data  = DATA_WIDTH'(build_header(16'(len_q), seq_q));
        if (skid_in_ready) begin
          seq_d   = seq_q + 32'd1;
          state_d = StData;
        end
      end
`endif
      StData: begin
        skid_in_valid = s_axis_tvalid;
        skid_in_data  = s_axis_tdata;
        skid_in_last  = pkt_end;
        if (s_axis_tvalid && skid_in_ready) begin
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          if (pkt_end) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
`ifdef RX_PKT_HEADER_EN
      seq_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef RX_PKT_HEADER_EN
      seq_q      <= seq_d;
`endif
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
    end
  end

  rx_axis_skid #(
    .Width(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i      (ACLK),
    .rst_ni     (ARESETN),
    .in_valid_i (skid_in_valid),
    .in_ready_o (skid_in_ready),
    .in_data_i  ({skid_in_last, skid_in_data}),
    .out_valid_o(m_axis_tvalid),
    .out_ready_i(m_axis_tready),
    .out_data_o (skid_out)
  );

endmodule

// File: tb/tb_rx_stream_packetizer.sv
// Self-checking bench for rx_stream_packetizer. Expected output is built from
// the packet rules directly: each queued input stream is split into packets of
// the configured length (or shorter on upstream tlast), optionally prefixed by
// a header beat, and the result is compared beat by beat.
module tb_rx_stream_packetizer;

  localparam int unsigned DW = 64;
  localparam int unsigned LW = 16;
  localparam int unsigned CW = DW + 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          cfg_enable;
  logic [LW-1:0] cfg_pkt_len;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic [31:0]   pkt_count;

  rx_stream_packetizer #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .ACLK         (aclk),
    .ARESETN      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .cfg_enable   (cfg_enable),
    .cfg_pkt_len  (cfg_pkt_len),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] src_data[$];
  logic          src_last[$];
  logic [DW:0]   exp_q[$];
  int unsigned   exp_pkts = 0;
  logic [31:0]   exp_seq = '0;

  int            rdy_pct = 100;
  int            vld_pct = 100;
  int            acc_cnt = 0;
  int            disable_at = 0;
  int            len_change_at = -1;
  logic [LW-1:0] len_change_val = '0;
  logic          in_pend = 1'b0;
  logic          stall = 1'b0;
  logic [DW:0]   stall_beat = '0;

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: split n beats into packets of len (early end at index 'early').
  task automatic queue_stream(input int n, input int len, input int early, input bit seq_data);
    int            cnt;
    logic [DW-1:0] d;
    logic          l;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      d = seq_data ? DW'(i) : {$urandom, $urandom};
      l = (i == early);
`ifdef RX_PKT_HEADER_EN
      if (cnt == 0) begin
        exp_q.push_back({1'b0, 16'hA55A, 16'(len), exp_seq});
        exp_seq = exp_seq + 32'd1;
      end
`endif
      cnt++;
      src_data.push_back(d);
      src_last.push_back(l);
      if (cnt == len || l) begin
        exp_q.push_back({1'b1, d});
        cnt = 0;
        exp_pkts++;
      end else begin
        exp_q.push_back({1'b0, d});
      end
    end
  endtask

  // One clock: retire last cycle's upstream handshake, check AXI stability,
  // drive new inputs and score any downstream beat taken on the next edge.
  task automatic sim_cycle();
    @(negedge aclk);
    if (in_pend) begin
      src_data.delete(0);
      src_last.delete(0);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      in_pend       = 1'b0;
      acc_cnt++;
      if (acc_cnt == len_change_at) cfg_pkt_len = len_change_val;
      if (acc_cnt == disable_at) cfg_enable = 1'b0;
    end
    if (stall) begin
      check("stall_valid", CW'(m_axis_tvalid), CW'(1));
      check("stall_beat", {m_axis_tlast, m_axis_tdata}, stall_beat);
    end
    m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
    if (!s_axis_tvalid && src_data.size() > 0 && int'($urandom_range(99)) < vld_pct) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_data[0];
      s_axis_tlast  = src_last[0];
    end
    if (m_axis_tvalid && m_axis_tready) begin
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL extra_beat: observed 0x%0h expected no beat", {m_axis_tlast, m_axis_tdata});
      end
      if (exp_q.size() > 0) check("out_beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
    end
    stall      = m_axis_tvalid && !m_axis_tready;
    stall_beat = {m_axis_tlast, m_axis_tdata};
    in_pend    = s_axis_tvalid && s_axis_tready;
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while ((src_data.size() > 0 || in_pend || exp_q.size() > 0) && cyc < budget) begin
      sim_cycle();
      cyc++;
    end
    n_tests++;
    assert (cyc < budget) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d beats outstanding expected 0", exp_q.size());
    end
    repeat (3) sim_cycle();
    check("idle_busy", CW'(busy), CW'(0));
    check("idle_valid", CW'(m_axis_tvalid), CW'(0));
    check("pkt_count", CW'(pkt_count), CW'(exp_pkts));
  endtask

  task automatic start_step(input int len, input int rdy, input int vld, input int dis_at);
    cfg_pkt_len   = LW'(len);
    rdy_pct       = rdy;
    vld_pct       = vld;
    acc_cnt       = 0;
    disable_at    = dis_at;
    len_change_at = -1;
    cfg_enable    = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed time limit reached expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    cfg_enable    = 1'b0;
    cfg_pkt_len   = '0;
    repeat (3) @(negedge aclk);
    check("rst_s_tready", CW'(s_axis_tready), CW'(0));
    check("rst_m_tvalid", CW'(m_axis_tvalid), CW'(0));
    check("rst_m_tlast", CW'(m_axis_tlast), CW'(0));
    check("rst_m_tdata", CW'(m_axis_tdata), CW'(0));
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_pkt_count", CW'(pkt_count), CW'(0));
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Zero length never starts a packet.
    cfg_enable = 1'b1;
    repeat (4) @(negedge aclk);
    check("len0_busy", CW'(busy), CW'(0));
    check("len0_tready", CW'(s_axis_tready), CW'(0));
    cfg_enable = 1'b0;

    // Three back-to-back 4-beat packets of data 0..11.
    start_step(4, 100, 100, 12);
    queue_stream(12, 4, -1, 1'b1);
    drain(500);

    // Upstream tlast on beat 2 ends a short packet; the next one is full length.
    start_step(4, 100, 100, 6);
    queue_stream(6, 4, 1, 1'b0);
    drain(500);

    // 64 beats in 8-beat packets under 50% downstream backpressure.
    start_step(8, 50, 100, 64);
    queue_stream(64, 8, -1, 1'b0);
    drain(3000);

    // Gappy upstream and downstream with an early end at beat 8.
    start_step(5, 60, 70, 18);
    queue_stream(18, 5, 7, 1'b0);
    drain(3000);

    // Length change mid-packet and enable drop in the following packet.
    start_step(4, 100, 100, 7);
    len_change_at  = 2;
    len_change_val = LW'(8);
    queue_stream(4, 4, -1, 1'b0);
    queue_stream(8, 8, -1, 1'b0);
    drain(500);
    for (int i = 0; i < 4; i++) begin
      src_data.push_back({$urandom, $urandom});
      src_last.push_back(1'b0);
    end
    repeat (10) begin
      sim_cycle();
      check("disabled_tready", CW'(s_axis_tready), CW'(0));
    end
    check("disabled_src_left", CW'(src_data.size()), CW'(4));
    src_data.delete();
    src_last.delete();
    s_axis_tvalid = 1'b0;

    // Length 3, two packets (header words carry sequence 0 and 1 when enabled).
    start_step(3, 100, 100, 6);
    queue_stream(6, 3, -1, 1'b1);
    drain(500);

    // Reset in the middle of a stalled packet.
    start_step(4, 0, 100, 100);
    queue_stream(4, 4, -1, 1'b0);
    repeat (6) sim_cycle();
    check("prerst_valid", CW'(m_axis_tvalid), CW'(1));
    check("prerst_busy", CW'(busy), CW'(1));
    aresetn = 1'b0;
    #1;
    check("midrst_m_tvalid", CW'(m_axis_tvalid), CW'(0));
    check("midrst_m_tlast", CW'(m_axis_tlast), CW'(0));
    check("midrst_s_tready", CW'(s_axis_tready), CW'(0));
    check("midrst_busy", CW'(busy), CW'(0));
    check("midrst_pkt_count", CW'(pkt_count), CW'(0));
    src_data.delete();
    src_last.delete();
    exp_q.delete();
    in_pend       = 1'b0;
    stall         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_enable    = 1'b0;
    exp_pkts      = 0;
    exp_seq       = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    start_step(2, 100, 100, 2);
    queue_stream(2, 2, -1, 1'b0);
    drain(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
